// File: rtl/rr_dispatch_pkg.sv
// Shared types and helpers for the round-robin grant dispatcher.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package rr_dispatch_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] src_t;

    // One-hot acknowledge vector for the given source index.
    function automatic logic [NUM_REQ-1:0] onehot_ack(input src_t src);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[src] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_dispatch_fifo.sv
// Synchronous FIFO holding captured {src, data} entries in arrival order.
// Latency: a pushed entry is visible at pop_dat one edge after the push.
// Backpressure: push ignored when full, pop ignored when empty; no bypass.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_dat    write request and entry
//   pop, pop_dat      read request and head entry (don't-care when empty)
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module rr_dispatch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 34,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A full FIFO never accepts a write, even when a pop frees a slot in
    // the same cycle; the slot becomes usable on the following cycle.
    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are log2(DEPTH) wide, so they wrap on their own.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/rr_grant_dispatch.sv
// Qualifies the arbiter's encoded grant, acks the winner and queues its payload.
// Latency: ack same cycle as qualified grant; payload at out_data one edge later.
// Backpressure: out_ready=0 fills DEPTH entries, then ack is withheld until a pop.
//
// Ports:
//   arb_clk, arb_rst              clock, asynchronous active-high reset
//   arb_req[3:0], arb_gnt[1:0]    live requests and encoded arbiter grant
//   req_data0..req_data3          requester payloads
//   req_ack[3:0]                  one-hot combinational acknowledge
//   out_valid/out_ready           output handshake
//   out_data, out_src             head entry payload and source index
//   fifo_count                    occupancy
//   stat_cnt0..stat_cnt3          per-requester saturating ack counters,
//                                 present only with RR_GRANT_DISPATCH_STATS_EN
module rr_grant_dispatch
    import rr_dispatch_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              arb_clk,
    input  logic              arb_rst,
    input  logic [3:0]        arb_req,
    input  logic [1:0]        arb_gnt,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    input  logic [DATA_W-1:0] req_data3,
    output logic [3:0]        req_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic [CNT_W-1:0]  fifo_count
`ifdef RR_GRANT_DISPATCH_STATS_EN
    ,
    output logic [15:0]       stat_cnt0,
    output logic [15:0]       stat_cnt1,
    output logic [15:0]       stat_cnt2,
    output logic [15:0]       stat_cnt3
`endif
);

    typedef struct packed {
        src_t              src;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              qual;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] sel_data;
    entry_t            push_ent;
    entry_t            head_ent;

    // The arbiter parks arb_gnt at 0 when idle, so a grant only counts
    // when the granted requester is still asserting its request.
    assign qual = arb_req[arb_gnt];
    assign push = qual && !full;
    assign pop  = out_valid && out_ready;

    assign req_ack = push ? onehot_ack(arb_gnt) : 4'b0000;

    always_comb begin
        sel_data = req_data0;
        case (arb_gnt)
            2'd0:    sel_data = req_data0;
            2'd1:    sel_data = req_data1;
            2'd2:    sel_data = req_data2;
            default: sel_data = req_data3;
        endcase
    end

    assign push_ent.src  = arb_gnt;
    assign push_ent.data = sel_data;

    rr_dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk      (arb_clk),
        .rst      (arb_rst),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .pop_dat  (head_ent),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    assign out_valid = !empty;
    assign out_data  = head_ent.data;
    assign out_src   = head_ent.src;

`ifdef RR_GRANT_DISPATCH_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat_cnt_q;
    logic [NUM_REQ-1:0][15:0] stat_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i] && (stat_cnt_q[i] != 16'hFFFF)) begin
                stat_cnt_d[i] = stat_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            stat_cnt_q <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_cnt0 = stat_cnt_q[0];
    assign stat_cnt1 = stat_cnt_q[1];
    assign stat_cnt2 = stat_cnt_q[2];
    assign stat_cnt3 = stat_cnt_q[3];
`endif

endmodule

// File: tb/tb_rr_grant_dispatch.sv
// Self-checking bench for rr_grant_dispatch: directed steps plus random traffic
// checked against a queue-based model of the dispatcher.
module tb_rr_grant_dispatch;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              arb_clk;
    logic              arb_rst;
    logic [3:0]        arb_req;
    logic [1:0]        arb_gnt;
    logic [DATA_W-1:0] req_data0, req_data1, req_data2, req_data3;
    logic [3:0]        req_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_src;
    logic [CNT_W-1:0]  fifo_count;
`ifdef RR_GRANT_DISPATCH_STATS_EN
    logic [15:0]       stat_cnt0, stat_cnt1, stat_cnt2, stat_cnt3;
`endif

    rr_grant_dispatch #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .arb_clk    (arb_clk),
        .arb_rst    (arb_rst),
        .arb_req    (arb_req),
        .arb_gnt    (arb_gnt),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .req_data3  (req_data3),
        .req_ack    (req_ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .fifo_count (fifo_count)
`ifdef RR_GRANT_DISPATCH_STATS_EN
        ,
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1),
        .stat_cnt2  (stat_cnt2),
        .stat_cnt3  (stat_cnt3)
`endif
    );

    initial arb_clk = 1'b0;
    always #5 arb_clk = ~arb_clk;

    typedef struct {
        logic [1:0]        src;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] d [4];
    int                ack_cnt [4];
    logic [3:0]        last_ack;
    logic [1:0]        last_head_src;
    int                n_assert;
    int                n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, advance model at posedge.
    task automatic cyc(input logic [3:0] req, input logic [1:0] gnt, input logic rdy);
        logic       granted_live;
        logic       room;
        logic [3:0] exp_ack;
        @(negedge arb_clk);
        arb_req   = req;
        arb_gnt   = gnt;
        out_ready = rdy;
        req_data0 = d[0];
        req_data1 = d[1];
        req_data2 = d[2];
        req_data3 = d[3];
        #1;
        granted_live = req[gnt];
        room         = (q.size() < DEPTH);
        exp_ack      = 4'b0000;
        if (granted_live && room) exp_ack[gnt] = 1'b1;
        last_ack = req_ack;
        chk("ack", 64'(req_ack), 64'(exp_ack));
        chk("valid", 64'(out_valid), 64'(q.size() != 0));
        chk("count", 64'(fifo_count), 64'(q.size()));
        last_head_src = out_src;
        if (q.size() != 0) begin
            chk("head_data", 64'(out_data), 64'(q[0].data));
            chk("head_src", 64'(out_src), 64'(q[0].src));
        end
        @(posedge arb_clk);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (granted_live && room) begin
            ent_t e;
            e.src  = gnt;
            e.data = d[gnt];
            q.push_back(e);
            if (ack_cnt[gnt] < 65535) ack_cnt[gnt]++;
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        arb_rst   = 1'b1;
        arb_req   = '0;
        arb_gnt   = '0;
        out_ready = 1'b0;
        req_data0 = '0;
        req_data1 = '0;
        req_data2 = '0;
        req_data3 = '0;
        for (int i = 0; i < 4; i++) d[i] = 32'h1000_0000 * (i + 1);
        model_reset();

        // Reset state
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        repeat (2) @(negedge arb_clk);
        arb_rst = 1'b0;

        // Idle arbiter: gnt=0 with no requests must not push
        cyc(4'b0000, 2'd0, 1'b0);
        chk("idle_ack", 64'(last_ack), 64'd0);
        #1;
        chk("idle_count", 64'(fifo_count), 64'd0);

        // Single capture, one-edge latency
        d[0] = 32'hA5A5_0000;
        cyc(4'b0001, 2'd0, 1'b0);
        chk("t1_ack", 64'(last_ack), 64'h1);
        #1;
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hA5A5_0000);
        chk("t1_src", 64'(out_src), 64'd0);
        chk("t1_count", 64'(fifo_count), 64'd1);
        cyc(4'b0000, 2'd0, 1'b1);

        // Backpressure: four rotating grants accepted, fifth refused
        for (int i = 0; i < 4; i++) begin
            d[i] = 32'hB000_0000 + i;
            cyc(4'b1111, 2'(i), 1'b0);
            chk("bp_ack", 64'(last_ack), 64'(4'b0001 << i));
        end
        #1;
        chk("bp_count_full", 64'(fifo_count), 64'd4);
        cyc(4'b1111, 2'd0, 1'b0);
        chk("bp_fifth_ack", 64'(last_ack), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0000, 2'd0, 1'b1);
            chk("bp_pop_src", 64'(last_head_src), 64'(i));
        end
        #1;
        chk("bp_drained", 64'(fifo_count), 64'd0);

        // Full with simultaneous pop and qualified grant: pop only
        for (int i = 0; i < 4; i++) cyc(4'b1111, 2'(i), 1'b0);
        cyc(4'b1111, 2'd1, 1'b1);
        chk("fullpop_ack", 64'(last_ack), 64'd0);
        #1;
        chk("fullpop_count", 64'(fifo_count), 64'd3);
        cyc(4'b1111, 2'd1, 1'b0);
        chk("after_ack", 64'(last_ack), 64'h2);
        #1;
        chk("after_count", 64'(fifo_count), 64'd4);

        // Reset mid-operation with three entries
        cyc(4'b0000, 2'd0, 1'b1);
        #1;
        chk("pre_rst_count", 64'(fifo_count), 64'd3);
        @(negedge arb_clk);
        arb_req = '0;
        arb_rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        model_reset();
        @(negedge arb_clk);
        arb_rst = 1'b0;

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int j = 0; j < 4; j++) d[j] = $urandom;
            cyc(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
        end

`ifdef RR_GRANT_DISPATCH_STATS_EN
        #1;
        chk("stat0", 64'(stat_cnt0), 64'(ack_cnt[0]));
        chk("stat1", 64'(stat_cnt1), 64'(ack_cnt[1]));
        chk("stat2", 64'(stat_cnt2), 64'(ack_cnt[2]));
        chk("stat3", 64'(stat_cnt3), 64'(ack_cnt[3]));
        @(negedge arb_clk);
        arb_req = '0;
        force dut.stat_cnt_q[2] = 16'hFFFE;
        @(posedge arb_clk);
        #1;
        release dut.stat_cnt_q[2];
        for (int i = 0; i < 3; i++) cyc(4'b0100, 2'd2, 1'b1);
        #1;
        chk("stat2_sat", 64'(stat_cnt2), 64'hFFFF);
        cyc(4'b0000, 2'd0, 1'b1);
        #1;
        chk("stat2_hold", 64'(stat_cnt2), 64'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
